// File: rtl/mc_ctrl.sv
// ============================================================================
// Module      : mc_ctrl
// Description : Multicycle MIPS control unit. Sequences fetch, decode,
//               execute, memory and write-back and drives datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       Branch_ne,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       Zext,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_Control,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_LW   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EX_R    = 4'd6,
    S_WB_R    = 4'd7,
    S_BR      = 4'd8,
    S_J       = 4'd9,
    S_EX_I    = 4'd10,
    S_WB_I    = 4'd11,
    S_JAL     = 4'd12
  } state_t;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_XOR = 3'b011;
  localparam logic [2:0] c_ALU_NOR = 3'b100;
  localparam logic [2:0] c_ALU_SRL = 3'b101;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_r_alu;
  logic       w_r_known;
  logic [2:0] w_i_alu;
  logic       w_i_zext;
  logic       w_i_lui;
  logic       w_unused_zero;

  // Branch condition is resolved in the datapath; the flag is only passed through.
  assign w_unused_zero = zero;
  assign state_out     = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_r_alu   = c_ALU_ADD;
    w_r_known = 1'b1;
    case (Fun)
      6'b100000: w_r_alu = c_ALU_ADD;
      6'b100010: w_r_alu = c_ALU_SUB;
      6'b100100: w_r_alu = c_ALU_AND;
      6'b100101: w_r_alu = c_ALU_OR;
      6'b100110: w_r_alu = c_ALU_XOR;
      6'b100111: w_r_alu = c_ALU_NOR;
      6'b101010: w_r_alu = c_ALU_SLT;
      6'b000010: w_r_alu = c_ALU_SRL;
      default:   w_r_known = 1'b0;
    endcase
  end

  always_comb begin
    w_i_alu  = c_ALU_ADD;
    w_i_zext = 1'b0;
    w_i_lui  = 1'b0;
    case (OP)
      6'b001010: w_i_alu = c_ALU_SLT;
      6'b001100: begin w_i_alu = c_ALU_AND; w_i_zext = 1'b1; end
      6'b001101: begin w_i_alu = c_ALU_OR;  w_i_zext = 1'b1; end
      6'b001110: begin w_i_alu = c_ALU_XOR; w_i_zext = 1'b1; end
      6'b001111: w_i_lui = 1'b1;
      default:   w_i_alu = c_ALU_ADD;
    endcase
  end

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:      w_next = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (OP)
          6'b000000:            w_next = S_EX_R;
          6'b100011, 6'b101011: w_next = S_MEM_ADR;
          6'b000100, 6'b000101: w_next = S_BR;
          6'b000010:            w_next = S_J;
          6'b000011:            w_next = S_JAL;
          6'b001000, 6'b001010, 6'b001100,
          6'b001101, 6'b001110, 6'b001111: w_next = S_EX_I;
          default:              w_next = S_IF;
        endcase
      end
      S_MEM_ADR: w_next = (OP == 6'b101011) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  w_next = MIO_ready ? S_WB_LW : S_MEM_RD;
      S_MEM_WR:  w_next = MIO_ready ? S_IF : S_MEM_WR;
      S_EX_R:    w_next = w_r_known ? S_WB_R : S_IF;
      S_EX_I:    w_next = S_WB_I;
      default:   w_next = S_IF;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch_ne   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    Zext        = 1'b0;
    PCSource    = 2'b00;
    ALU_Control = c_ALU_ADD;
    case (r_state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
      end
      S_ID:      ALUSrcB = 2'b11;
      S_MEM_ADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_MEM_RD:  begin IorD = 1'b1; MemRead = 1'b1; end
      S_WB_LW:   begin MemtoReg = 2'b01; RegWrite = 1'b1; end
      S_MEM_WR:  begin IorD = 1'b1; MemWrite = 1'b1; end
      S_EX_R: begin
        ALUSrcA     = 1'b1;
        ALU_Control = w_r_alu;
      end
      S_WB_R: begin
        RegDst      = 2'b01;
        RegWrite    = 1'b1;
        ALU_Control = w_r_alu;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALU_Control = c_ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Branch_ne   = (OP == 6'b000101);
      end
      S_J:       begin PCWrite = 1'b1; PCSource = 2'b10; end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
      S_EX_I: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        Zext        = w_i_zext;
        ALU_Control = w_i_alu;
      end
      S_WB_I: begin
        RegWrite    = 1'b1;
        MemtoReg    = w_i_lui ? 2'b11 : 2'b00;
        ALU_Control = w_i_alu;
      end
      default: ALU_Control = c_ALU_ADD;
    endcase
    // Reset must suppress architectural writes even before the state flop settles.
    if (rst) begin
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed scoreboard bench for mc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OP, Fun;
  logic       MIO_ready, zero;
  logic       PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, PCSource;
  logic       RegWrite, ALUSrcA, Zext;
  logic [2:0] ALU_Control;
  logic [3:0] state_out;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .OP(OP), .Fun(Fun), .MIO_ready(MIO_ready), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch_ne(Branch_ne),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .Zext(Zext), .PCSource(PCSource),
    .ALU_Control(ALU_Control), .state_out(state_out)
  );

  typedef struct {
    logic [3:0] st;
    logic       pcw, pcwc, bne, iord, mr, mw, irw;
    logic [1:0] m2r, rdst;
    logic       rw, asa;
    logic [1:0] asb;
    logic       zx;
    logic [1:0] pcs;
    logic [2:0] alu;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [24:0] obs;
  assign obs = {PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, Zext, PCSource,
                ALU_Control, state_out};

  function automatic logic [24:0] pk(input exp_t e);
    return {e.pcw, e.pcwc, e.bne, e.iord, e.mr, e.mw, e.irw, e.m2r, e.rdst,
            e.rw, e.asa, e.asb, e.zx, e.pcs, e.alu, e.st};
  endfunction

  function automatic exp_t base(input logic [3:0] st, input string tag);
    exp_t e;
    e.st = st; e.pcw = 0; e.pcwc = 0; e.bne = 0; e.iord = 0; e.mr = 0; e.mw = 0;
    e.irw = 0; e.m2r = 2'b00; e.rdst = 2'b00; e.rw = 0; e.asa = 0; e.asb = 2'b00;
    e.zx = 0; e.pcs = 2'b00; e.alu = 3'b010; e.rdy = 1'b1; e.tag = tag;
    return e;
  endfunction

  // Expected per-state output sets, one builder per control state
  function automatic exp_t e_if(input logic rdy);
    exp_t e = base(4'd0, "IF");
    e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; e.rdy = rdy;
    return e;
  endfunction
  function automatic exp_t e_id();
    exp_t e = base(4'd1, "ID");
    e.asb = 2'b11;
    return e;
  endfunction
  function automatic exp_t e_memadr();
    exp_t e = base(4'd2, "MEM_ADR");
    e.asa = 1; e.asb = 2'b10;
    return e;
  endfunction
  function automatic exp_t e_memrd(input logic rdy);
    exp_t e = base(4'd3, "MEM_RD");
    e.iord = 1; e.mr = 1; e.rdy = rdy;
    return e;
  endfunction
  function automatic exp_t e_wblw();
    exp_t e = base(4'd4, "WB_LW");
    e.m2r = 2'b01; e.rw = 1;
    return e;
  endfunction
  function automatic exp_t e_memwr(input logic rdy);
    exp_t e = base(4'd5, "MEM_WR");
    e.iord = 1; e.mw = 1; e.rdy = rdy;
    return e;
  endfunction
  function automatic exp_t e_exr(input logic [2:0] alu);
    exp_t e = base(4'd6, "EX_R");
    e.asa = 1; e.alu = alu;
    return e;
  endfunction
  function automatic exp_t e_wbr(input logic [2:0] alu);
    exp_t e = base(4'd7, "WB_R");
    e.rdst = 2'b01; e.rw = 1; e.alu = alu;
    return e;
  endfunction
  function automatic exp_t e_br(input logic ne);
    exp_t e = base(4'd8, "BR");
    e.asa = 1; e.alu = 3'b110; e.pcwc = 1; e.pcs = 2'b01; e.bne = ne;
    return e;
  endfunction
  function automatic exp_t e_j();
    exp_t e = base(4'd9, "J");
    e.pcw = 1; e.pcs = 2'b10;
    return e;
  endfunction
  function automatic exp_t e_jal();
    exp_t e = base(4'd12, "JAL");
    e.pcw = 1; e.pcs = 2'b10; e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10;
    return e;
  endfunction
  function automatic exp_t e_exi(input logic [2:0] alu, input logic zx);
    exp_t e = base(4'd10, "EX_I");
    e.asa = 1; e.asb = 2'b10; e.zx = zx; e.alu = alu;
    return e;
  endfunction
  function automatic exp_t e_wbi(input logic [2:0] alu, input logic lui);
    exp_t e = base(4'd11, "WB_I");
    e.rw = 1; e.alu = alu; e.m2r = lui ? 2'b11 : 2'b00;
    return e;
  endfunction

  task automatic check_front();
    exp_t e;
    n_assert++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required an entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === pk(e)) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, pk(e));
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] x);
    n_assert++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask

  // One clock per queued entry; inputs change just after the rising edge.
  task automatic drain();
    while (q.size() > 0) begin
      MIO_ready = q[0].rdy;
      @(negedge clk);
      check_front();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    OP = op; Fun = fn;
  endtask

  initial begin
    rst = 1'b1; OP = 6'd0; Fun = 6'd0; MIO_ready = 1'b1; zero = 1'b0;
    q.push_back(e_if(1'b1));
    @(negedge clk); check_front();
    @(posedge clk); #1 rst = 1'b0;

    instr(6'b000000, 6'b100000);   // add
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exr(3'b010)); q.push_back(e_wbr(3'b010));
    drain();
    instr(6'b000000, 6'b100010);   // sub
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exr(3'b110)); q.push_back(e_wbr(3'b110));
    drain();
    instr(6'b000000, 6'b000010);   // srl
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exr(3'b101)); q.push_back(e_wbr(3'b101));
    drain();
    instr(6'b000000, 6'b111111);   // unknown funct: no write-back
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exr(3'b010));
    drain();

    instr(6'b100011, 6'b000000);   // lw with two wait cycles
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_memadr());
    q.push_back(e_memrd(0)); q.push_back(e_memrd(0)); q.push_back(e_memrd(1)); q.push_back(e_wblw());
    drain();
    instr(6'b101011, 6'b000000);   // sw with a fetch stall and a write stall
    q.push_back(e_if(0)); q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_memadr());
    q.push_back(e_memwr(0)); q.push_back(e_memwr(1));
    drain();

    instr(6'b000101, 6'b000000); zero = 1'b1;
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_br(1));
    drain();
    instr(6'b000100, 6'b000000); zero = 1'b0;
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_br(0));
    drain();
    instr(6'b000010, 6'b000000);
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_j());
    drain();
    instr(6'b000011, 6'b000000);
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_jal());
    drain();

    instr(6'b001101, 6'b000000);   // ori
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exi(3'b001, 1)); q.push_back(e_wbi(3'b001, 0));
    drain();
    instr(6'b001111, 6'b000000);   // lui
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exi(3'b010, 0)); q.push_back(e_wbi(3'b010, 1));
    drain();
    instr(6'b001010, 6'b000000);   // slti
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exi(3'b111, 0)); q.push_back(e_wbi(3'b111, 0));
    drain();
    instr(6'b001110, 6'b000000);   // xori
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_exi(3'b011, 1)); q.push_back(e_wbi(3'b011, 0));
    drain();

    instr(6'b111111, 6'b000000);   // illegal opcode falls back to fetch
    q.push_back(e_if(1)); q.push_back(e_id());
    drain();

    instr(6'b101011, 6'b000000);   // sw aborted by asynchronous reset
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_memadr());
    drain();
    MIO_ready = 1'b0;
    q.push_back(e_memwr(0));
    @(negedge clk); check_front();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_state", state_out, 4'd0);
    chk("rst_memwrite", {3'b000, MemWrite}, 4'd0);
    chk("rst_regwrite", {3'b000, RegWrite}, 4'd0);
    q.push_back(e_if(0)); check_front();
    @(posedge clk); #1;
    q.push_back(e_if(0));
    @(negedge clk); check_front();
    @(posedge clk); #1 rst = 1'b0;

    instr(6'b000010, 6'b000000);   // fetch resumes after reset
    q.push_back(e_if(1)); q.push_back(e_id()); q.push_back(e_j()); q.push_back(e_if(1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle MIPS control unit. It sequences the datapath through fetch, decode, execute, memory and write-back, and drives the register file's write enable, write-address select and write-data select. It sits upstream of the register file and ALU, decoding the instruction register's opcode/funct each instruction. Memory handshake: a single ready input stretches memory states.

Parameters:
None (encodings fixed below).

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset, asynchronous, active-high
OP  in  6  IR[31:26]
Fun  in  6  IR[5:0]
MIO_ready  in  1  memory access complete this cycle
zero  in  1  ALU zero flag (used by datapath for branch; passed through, unused internally)
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load (datapath ANDs with zero or ~zero)
Branch_ne  out  1  1 = condition is ~zero (bne)
IorD  out  1  memory address: 0 PC, 1 ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  load IR and PC+4 path
MemtoReg  out  2  reg write data: 00 ALUOut, 01 MDR, 10 PC, 11 {imm,16'b0}
RegDst  out  2  write addr: 00 rt, 01 rd, 10 5'd31
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 PC, 1 rs data
ALUSrcB  out  2  00 rt data, 01 const 4, 10 ext imm, 11 sext imm<<2
Zext  out  1  imm extension: 1 zero-extend (andi/ori/xori), 0 sign-extend
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
ALU_Control  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 xor, 101 srl
state_out  out  4  current state (debug)

Behaviour:
- State register, 4 bits. Encodings: IF 0, ID 1, MEM_ADR 2, MEM_RD 3, WB_LW 4, MEM_WR 5, EX_R 6, WB_R 7, BR 8, J 9, EX_I 10, WB_I 11, JAL 12. Codes 13-15 go to IF next cycle with all strobes 0.
- rst=1 forces state IF asynchronously. Held in reset, outputs are the IF decode. RegWrite=0 and MemWrite=0 while rst=1 regardless of state.
- Outputs are decoded combinationally from state (plus OP/Fun where noted). Every output not listed for a state is 0. ALU_Control defaults to 010.
- IF: MemRead=1, ALUSrcB=01, add. IRWrite=PCWrite=MIO_ready. Go to ID when MIO_ready, else stay.
- ID: ALUSrcB=11, add (branch target into ALUOut). Next state by OP:
  - R 000000: EX_R
  - lw 100011 / sw 101011: MEM_ADR
  - beq 000100 / bne 000101: BR
  - j 000010: J
  - jal 000011: JAL
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111: EX_I
  - any other opcode: IF, with no write or memory strobe.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: IorD=1, MemRead=1. Go to WB_LW on MIO_ready, else stay.
- WB_LW: RegDst=00, MemtoReg=01, RegWrite=1. Go to IF.
- MEM_WR: IorD=1, MemWrite=1. Go to IF on MIO_ready, else stay (MemWrite held).
- EX_R: ALUSrcA=1, ALUSrcB=00. ALU_Control from Fun: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, srl 000010. Unknown Fun gives add, and the next state is IF (no write). Known Fun goes to WB_R; ALU_Control in WB_R keeps the same Fun decode.
- WB_R: RegDst=01, MemtoReg=00, RegWrite=1. Go to IF.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, Branch_ne=(OP==000101). Go to IF.
- J: PCWrite=1, PCSource=10. Go to IF.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. The register file captures the pre-edge PC (already PC+4). Go to IF.
- EX_I: ALUSrcA=1, ALUSrcB=10. Zext=1 for andi/ori/xori. ALU op: add/slt/and/or/xor per opcode; lui uses add. Go to WB_I; WB_I repeats the same ALU decode.
- WB_I: RegDst=00, RegWrite=1. MemtoReg=11 for lui, else 00. Go to IF.
- Latency with MIO_ready=1 throughout: R 4, I 4, lw 5, sw 4, beq/bne 3, j 3, jal 3 cycles. Each cycle with MIO_ready=0 in IF/MEM_RD/MEM_WR adds one cycle.
- Async reset mid-instruction aborts it. No further strobes after rst rises; fetch resumes from IF after release.

Test Plan:
- OP=000000, Fun=100000, MIO_ready=1 -> states 0,1,6,7,0. RegWrite=1, RegDst=01 only in state 7. ALU_Control=010.
- lw (OP=100011) with MIO_ready=0 for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0. MemRead=1 throughout state 3. WB_LW has MemtoReg=01, RegWrite=1.
- bne (OP=000101) -> state 8 with PCWriteCond=1, Branch_ne=1, PCSource=01, ALU_Control=110. beq gives Branch_ne=0. 3 cycles.
- jal (OP=000011) -> state 12 with PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. Next state 0.
- ori then lui -> ori: Zext=1, ALU_Control=001, MemtoReg=00. lui: MemtoReg=11, RegWrite=1 in state 11.
- Illegal OP=111111, then rst asserted mid-state 5 (sw) -> illegal returns 0 from ID with no RegWrite/MemWrite. rst forces state 0 immediately (no clock) with MemWrite=0.
